quad_axis_driver: RTL and testbench

QUAD_AXIS_DRIVER -- requirements
Module: quad_axis_driver

---
 rtl/quad_axis_driver.sv | 150 +++++++++++++++
 tb/tb_quad_axis_driver.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_axis_driver.sv
// Quadrature step driver for up to four independent axes.
// A free-running prescaler produces a step tick; each running axis advances its
// two-bit Gray phase and signed position once per tick until its step count is used up.
module quad_axis_driver #(
    parameter int unsigned NUM_AXES = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned STEP_W   = 8,
    parameter int unsigned POS_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_axis,
    input  logic                       cmd_dir,
    input  logic [STEP_W-1:0]          cmd_steps,
    input  logic                       abort,
    output logic [2*NUM_AXES-1:0]      phase,
    output logic [NUM_AXES-1:0]        busy,
    output logic [NUM_AXES-1:0]        done,
    output logic [POS_W*NUM_AXES-1:0]  pos,
    output logic                       tick
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

    typedef enum logic {
        StIdle,
        StRun
    } axis_state_e;

    logic [CNT_W-1:0]                   presc_q, presc_d;
    axis_state_e                        state_q [NUM_AXES];
    axis_state_e                        state_d [NUM_AXES];
    logic [NUM_AXES-1:0]                dir_q, dir_d;
    logic [NUM_AXES-1:0][STEP_W-1:0]    rem_q, rem_d;
    logic [NUM_AXES-1:0][1:0]           phase_q, phase_d;
    logic [NUM_AXES-1:0][POS_W-1:0]     pos_q, pos_d;
    logic [NUM_AXES-1:0]                done_q, done_d;
    logic [3:0]                         busy_pad;
    logic                               axis_ok;
    logic                               accept;

    // Next Gray code in the forward (00,01,11,10) or reverse direction.
    function automatic logic [1:0] gray_step(input logic [1:0] p, input logic fwd);
        logic [1:0] n;
        unique case (p)
            2'b00:   n = fwd ? 2'b01 : 2'b10;
            2'b01:   n = fwd ? 2'b11 : 2'b00;
            2'b11:   n = fwd ? 2'b10 : 2'b01;
            default: n = fwd ? 2'b00 : 2'b11;
        endcase
        return n;
    endfunction

    // Tick is forced low while reset is held so no output glitches during reset.
    assign tick = ~reset & (presc_q == CNT_MAX);

    // Prescaler wraps at PRESCALE-1; it never looks at commands or abort.
    always_comb begin
        presc_d = presc_q + CNT_W'(1);
        if (presc_q == CNT_MAX) begin
            presc_d = '0;
        end
    end

    // Command handshake: refuse during abort, for absent axes and for busy axes.
    always_comb begin
        busy_pad = '0;
        for (int unsigned i = 0; i < NUM_AXES; i++) begin
            busy_pad[i] = (state_q[i] == StRun);
        end
        axis_ok   = (32'(cmd_axis) < NUM_AXES);
        cmd_ready = ~abort & axis_ok & ~busy_pad[cmd_axis];
        accept    = cmd_valid & cmd_ready;
    end

    // Per-axis next state: abort beats stepping, stepping only happens in RUN,
    // and acceptance only reaches an IDLE axis so it can never step on its accept edge.
    always_comb begin
        for (int unsigned i = 0; i < NUM_AXES; i++) begin
            state_d[i] = state_q[i];
            dir_d[i]   = dir_q[i];
            rem_d[i]   = rem_q[i];
            phase_d[i] = phase_q[i];
            pos_d[i]   = pos_q[i];
            done_d[i]  = 1'b0;
            if (abort) begin
                state_d[i] = StIdle;
                rem_d[i]   = '0;
            end else if (state_q[i] == StRun) begin
                if (tick) begin
                    phase_d[i] = gray_step(phase_q[i], dir_q[i]);
                    pos_d[i]   = dir_q[i] ? pos_q[i] + POS_W'(1) : pos_q[i] - POS_W'(1);
                    rem_d[i]   = rem_q[i] - STEP_W'(1);
                    if (rem_q[i] == STEP_W'(1)) begin
                        state_d[i] = StIdle;
                        done_d[i]  = 1'b1;
                    end
                end
            end else if (accept && (32'(cmd_axis) == i)) begin
                if (cmd_steps != '0) begin
                    state_d[i] = StRun;
                    dir_d[i]   = cmd_dir;
                    rem_d[i]   = cmd_steps;
                end else begin
                    done_d[i] = 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            dir_q   <= '0;
            rem_q   <= '0;
            phase_q <= '0;
            pos_q   <= '0;
            done_q  <= '0;
            for (int unsigned i = 0; i < NUM_AXES; i++) begin
                state_q[i] <= StIdle;
            end
        end else begin
            presc_q <= presc_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            phase_q <= phase_d;
            pos_q   <= pos_d;
            done_q  <= done_d;
            for (int unsigned i = 0; i < NUM_AXES; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Output mapping.
    always_comb begin
        for (int unsigned i = 0; i < NUM_AXES; i++) begin
            busy[i] = (state_q[i] == StRun);
        end
    end

    assign phase = phase_q;
    assign pos   = pos_q;
    assign done  = done_q;

endmodule

// File: tb/tb_quad_axis_driver.sv
// Bench for quad_axis_driver: directed scenarios plus random traffic checked
// against a step-count model of each axis.
module tb_quad_axis_driver;

    localparam int NA = 3;
    localparam int PS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_axis;
    logic        cmd_dir;
    logic [7:0]  cmd_steps;
    logic        abort;
    logic [5:0]  phase;
    logic [2:0]  busy;
    logic [2:0]  done;
    logic [47:0] pos;
    logic        tick;

    int n_checks = 0;
    int n_errors = 0;

    // Model: prescaler count, and per axis busy/direction/steps left/position.
    int          m_cnt;
    logic [2:0]  m_busy, m_dir, m_done;
    int          m_rem [NA];
    logic [15:0] m_pos [NA];

    quad_axis_driver #(
        .NUM_AXES(NA),
        .PRESCALE(PS),
        .STEP_W(8),
        .POS_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_axis(cmd_axis),
        .cmd_dir(cmd_dir),
        .cmd_steps(cmd_steps),
        .abort(abort),
        .phase(phase),
        .busy(busy),
        .done(done),
        .pos(pos),
        .tick(tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Quadrature phase is fixed by position modulo 4 since both start at zero.
    function automatic logic [1:0] gray_of(input logic [15:0] p);
        logic [1:0] g;
        case (p[1:0])
            2'd0:    g = 2'b00;
            2'd1:    g = 2'b01;
            2'd2:    g = 2'b11;
            default: g = 2'b10;
        endcase
        return g;
    endfunction

    function automatic logic exp_ready();
        if (abort || cmd_axis >= 2'(NA)) return 1'b0;
        return ~m_busy[cmd_axis];
    endfunction

    // Advance the model with the inputs present before the edge, then clock the DUT.
    task automatic clk_step();
        logic t;
        logic rdy;
        t   = (m_cnt == PS - 1);
        rdy = exp_ready();
        if (reset) begin
            m_cnt = 0;
            m_busy = '0; m_dir = '0; m_done = '0;
            for (int i = 0; i < NA; i++) begin
                m_rem[i] = 0;
                m_pos[i] = '0;
            end
        end else begin
            m_cnt = (m_cnt + 1) % PS;
            for (int i = 0; i < NA; i++) begin
                m_done[i] = 1'b0;
                if (abort) begin
                    m_busy[i] = 1'b0;
                    m_rem[i]  = 0;
                end else if (m_busy[i]) begin
                    if (t) begin
                        m_pos[i] = m_dir[i] ? m_pos[i] + 16'd1 : m_pos[i] - 16'd1;
                        m_rem[i] = m_rem[i] - 1;
                        if (m_rem[i] == 0) begin
                            m_busy[i] = 1'b0;
                            m_done[i] = 1'b1;
                        end
                    end
                end else if (cmd_valid && rdy && int'(cmd_axis) == i) begin
                    if (cmd_steps != 0) begin
                        m_busy[i] = 1'b1;
                        m_dir[i]  = cmd_dir;
                        m_rem[i]  = int'(cmd_steps);
                    end else begin
                        m_done[i] = 1'b1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        cmd_valid = 1'b0;
        cmd_axis  = 2'd0;
        cmd_dir   = 1'b0;
        cmd_steps = 8'd0;
        abort     = 1'b0;
    endtask

    // Offer one command for a single cycle and confirm it is acceptable.
    task automatic issue(input logic [1:0] ax, input logic dir, input logic [7:0] steps);
        cmd_valid = 1'b1;
        cmd_axis  = ax;
        cmd_dir   = dir;
        cmd_steps = steps;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL issue_ready axis%0d: got %b want 1", ax, cmd_ready);
        end
        clk_step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        int nt;
        set_idle();
        reset = 1'b1;
        clk_step();
        clk_step();
        n_checks++;
        if (tick !== 1'b0 || phase !== '0 || pos !== '0 || busy !== '0 || done !== '0) begin
            n_errors++;
            $display("FAIL reset_hold: tick=%b phase=%h pos=%h busy=%b done=%b want all 0",
                     tick, phase, pos, busy, done);
        end
        reset = 1'b0;
        nt = 0;
        for (int c = 0; c < 12; c++) begin
            n_checks++;
            if (tick !== ((c % 4) == 3)) begin
                n_errors++;
                $display("FAIL tick_period cycle%0d: got %b want %b", c, tick, (c % 4) == 3);
            end
            if (tick === 1'b1) nt++;
            if (c == 0) begin
                n_checks++;
                if (phase !== '0 || pos !== '0 || busy !== '0 || done !== '0) begin
                    n_errors++;
                    $display("FAIL reset_outputs: phase=%h pos=%h busy=%b done=%b want 0",
                             phase, pos, busy, done);
                end
            end
            clk_step();
        end
        n_checks++;
        if (nt != 3) begin
            n_errors++;
            $display("FAIL tick_count: got %0d want 3", nt);
        end
    endtask

    // Run one axis until it has seen n tick edges, checking each phase against a list.
    task automatic walk(input int ax, input int n, input logic [1:0] exp_ph [5],
                        output int dones);
        int  k;
        logic pre;
        k = 0;
        dones = 0;
        for (int c = 0; c < 60 && k < n; c++) begin
            pre = (m_cnt == PS - 1);
            clk_step();
            if (done[ax] === 1'b1) dones++;
            if (pre) begin
                n_checks++;
                if (phase[2*ax +: 2] !== exp_ph[k]) begin
                    n_errors++;
                    $display("FAIL walk_phase axis%0d step%0d: got %b want %b",
                             ax, k, phase[2*ax +: 2], exp_ph[k]);
                end
                k++;
            end
        end
        if (k < n) begin
            n_checks++;
            n_errors++;
            $display("FAIL walk_timeout axis%0d: got %0d ticks want %0d", ax, k, n);
        end
        for (int c = 0; c < 3; c++) begin
            clk_step();
            if (done[ax] === 1'b1) dones++;
        end
    endtask

    task automatic test_forward();
        logic [1:0] ph [5];
        int dones;
        ph = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
        issue(2'd0, 1'b1, 8'd5);
        n_checks++;
        if (busy[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL fwd_busy: got %b want 1", busy[0]);
        end
        walk(0, 5, ph, dones);
        n_checks++;
        if (pos[15:0] !== 16'd5 || busy[0] !== 1'b0 || dones != 1) begin
            n_errors++;
            $display("FAIL fwd_end: pos=%h busy=%b dones=%0d want 0005 0 1",
                     pos[15:0], busy[0], dones);
        end
    endtask

    task automatic test_reverse();
        logic [1:0] ph [5];
        int dones;
        ph = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b00};
        issue(2'd1, 1'b0, 8'd3);
        walk(1, 3, ph, dones);
        n_checks++;
        if (pos[31:16] !== 16'hFFFD || busy[1] !== 1'b0 || dones != 1) begin
            n_errors++;
            $display("FAIL rev_end: pos=%h busy=%b dones=%0d want fffd 0 1",
                     pos[31:16], busy[1], dones);
        end
        issue(2'd1, 1'b1, 8'd0);
        n_checks++;
        if (done !== 3'b010 || busy[1] !== 1'b0 || pos[31:16] !== 16'hFFFD) begin
            n_errors++;
            $display("FAIL zero_steps: done=%b busy=%b pos=%h want 010 0 fffd",
                     done, busy[1], pos[31:16]);
        end
        clk_step();
        n_checks++;
        if (done !== 3'b000) begin
            n_errors++;
            $display("FAIL zero_steps_pulse: done=%b want 000", done);
        end
    endtask

    task automatic test_refuse();
        issue(2'd0, 1'b1, 8'd10);
        cmd_valid = 1'b1; cmd_axis = 2'd0; cmd_dir = 1'b0; cmd_steps = 8'd2;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_refuse: cmd_ready=%b want 0", cmd_ready);
        end
        clk_step();
        n_checks++;
        if (busy !== m_busy || pos[15:0] !== m_pos[0] || phase[1:0] !== gray_of(m_pos[0])) begin
            n_errors++;
            $display("FAIL busy_state: busy=%b pos=%h want %b %h", busy, pos[15:0],
                     m_busy, m_pos[0]);
        end
        cmd_axis = 2'd3;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL bad_axis: cmd_ready=%b want 0", cmd_ready);
        end
        clk_step();
        cmd_valid = 1'b0;
        n_checks++;
        if (busy !== m_busy || done !== 3'b000) begin
            n_errors++;
            $display("FAIL bad_axis_state: busy=%b done=%b want %b 000", busy, done, m_busy);
        end
    endtask

    task automatic test_abort();
        logic [15:0] p0, p2;
        issue(2'd2, 1'b1, 8'd20);
        for (int c = 0; c < 9; c++) clk_step();
        abort = 1'b1;
        cmd_valid = 1'b1; cmd_axis = 2'd1; cmd_dir = 1'b1; cmd_steps = 8'd3;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_ready: cmd_ready=%b want 0", cmd_ready);
        end
        p0 = m_pos[0];
        p2 = m_pos[2];
        clk_step();
        abort = 1'b0;
        cmd_valid = 1'b0;
        n_checks++;
        if (busy !== 3'b000 || done !== 3'b000) begin
            n_errors++;
            $display("FAIL abort_clear: busy=%b done=%b want 000 000", busy, done);
        end
        for (int c = 0; c < 9; c++) begin
            n_checks++;
            if (pos[15:0] !== p0 || pos[47:32] !== p2 || phase[1:0] !== gray_of(p0)
                || phase[5:4] !== gray_of(p2) || done !== 3'b000 || busy !== 3'b000) begin
                n_errors++;
                $display("FAIL abort_freeze c%0d: pos0=%h pos2=%h done=%b want %h %h 000",
                         c, pos[15:0], pos[47:32], done, p0, p2);
            end
            clk_step();
        end
    endtask

    task automatic test_tick_accept();
        logic [15:0] p;
        for (int c = 0; c < 8 && m_cnt != PS - 1; c++) clk_step();
        n_checks++;
        if (tick !== 1'b1) begin
            n_errors++;
            $display("FAIL tick_align: tick=%b want 1", tick);
        end
        p = m_pos[0];
        issue(2'd0, 1'b1, 8'd2);
        for (int c = 0; c < 3; c++) begin
            n_checks++;
            if (pos[15:0] !== p || busy[0] !== 1'b1) begin
                n_errors++;
                $display("FAIL tick_accept_hold c%0d: pos=%h busy=%b want %h 1",
                         c, pos[15:0], busy[0], p);
            end
            clk_step();
        end
        clk_step();
        n_checks++;
        if (pos[15:0] !== p + 16'd1 || phase[1:0] !== gray_of(p + 16'd1)) begin
            n_errors++;
            $display("FAIL tick_accept_step: pos=%h phase=%b want %h %b",
                     pos[15:0], phase[1:0], p + 16'd1, gray_of(p + 16'd1));
        end
    endtask

    task automatic test_reset_mid();
        issue(2'd1, 1'b0, 8'd10);
        issue(2'd2, 1'b1, 8'd10);
        for (int c = 0; c < 6; c++) clk_step();
        reset = 1'b1;
        clk_step();
        n_checks++;
        if (phase !== '0 || pos !== '0 || busy !== '0 || done !== '0 || tick !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_mid: phase=%h pos=%h busy=%b done=%b tick=%b want 0",
                     phase, pos, busy, done, tick);
        end
        reset = 1'b0;
        clk_step();
        n_checks++;
        if (done !== '0 || busy !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_after: done=%b busy=%b want 000 000", done, busy);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_axis  = 2'($urandom_range(0, 3));
            cmd_dir   = 1'($urandom_range(0, 1));
            cmd_steps = 8'($urandom_range(0, 6));
            abort     = ($urandom_range(0, 50) == 0);
            #1;
            n_checks++;
            if (cmd_ready !== exp_ready() || tick !== (m_cnt == PS - 1)) begin
                n_errors++;
                $display("FAIL rand_comb c%0d: ready=%b tick=%b want %b %b",
                         c, cmd_ready, tick, exp_ready(), m_cnt == PS - 1);
            end
            clk_step();
            n_checks++;
            if (busy !== m_busy || done !== m_done) begin
                n_errors++;
                $display("FAIL rand_flags c%0d: busy=%b done=%b want %b %b",
                         c, busy, done, m_busy, m_done);
            end
            for (int i = 0; i < NA; i++) begin
                n_checks++;
                if (pos[16*i +: 16] !== m_pos[i] || phase[2*i +: 2] !== gray_of(m_pos[i])) begin
                    n_errors++;
                    $display("FAIL rand_axis%0d c%0d: pos=%h phase=%b want %h %b", i, c,
                             pos[16*i +: 16], phase[2*i +: 2], m_pos[i], gray_of(m_pos[i]));
                end
            end
        end
        set_idle();
    endtask

    initial begin
        m_cnt = 0;
        reset = 1'b1;
        set_idle();
        #1;
        test_reset();
        test_forward();
        test_reverse();
        test_refuse();
        test_abort();
        test_tick_accept();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
